// File: rtl/zbus_pkg.sv
// Shared definitions for the ZX-bus initiator.
// - Command type codes as carried on cmd_type.
// - FSM state encoding (IDLE, T1, T2, TW, T3).
// - T-state phase helpers: half point and last fclk of a T-state.
package zbus_pkg;

    // cmd_type encoding: bit 1 selects IO space, bit 0 selects write
    localparam logic [1:0] CmdMemRd = 2'b00;
    localparam logic [1:0] CmdMemWr = 2'b01;
    localparam logic [1:0] CmdIoRd  = 2'b10;
    localparam logic [1:0] CmdIoWr  = 2'b11;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StT1   = 3'd1;
    localparam logic [2:0] StT2   = 3'd2;
    localparam logic [2:0] StTw   = 3'd3;
    localparam logic [2:0] StT3   = 3'd4;

    function automatic logic cmd_is_io(input logic [1:0] t);
        return t[1];
    endfunction

    function automatic logic cmd_is_wr(input logic [1:0] t);
        return t[0];
    endfunction

    function automatic int unsigned tstate_half(input int unsigned tdiv);
        return tdiv / 2;
    endfunction

    function automatic int unsigned tstate_last(input int unsigned tdiv);
        return tdiv - 1;
    endfunction

endpackage

// File: rtl/zbus_tcnt.sv
// T-state divider: counts fclk cycles 0..TDIV-1 within one Z80 T-state.
// Ports:
//   fclk, zrst_n  clock / async active-low reset
//   clr           hold the counter at 0 (bus idle)
//   jump          load the half point next (timeout skip into T3 mid)
//   tc_next       next counter value (lets the owner register glitch-free strobes)
//   t_pre_mid     current fclk is the last one before the half point
//   t_mid         current fclk is the half point
//   t_last        current fclk is the last of the T-state
module zbus_tcnt
    import zbus_pkg::*;
#(
    parameter int unsigned TDIV = 4,
    parameter int unsigned CW   = $clog2(TDIV)
) (
    input  logic          fclk,
    input  logic          zrst_n,
    input  logic          clr,
    input  logic          jump,
    output logic [CW-1:0] tc_next,
    output logic          t_pre_mid,
    output logic          t_mid,
    output logic          t_last
);

    localparam logic [CW-1:0] HalfTc = CW'(tstate_half(TDIV));
    localparam logic [CW-1:0] LastTc = CW'(tstate_last(TDIV));

    logic [CW-1:0] tc_q, tc_d;

    always_comb begin
        tc_d = tc_q + 1'b1;
        if (clr) begin
            tc_d = '0;
        end else if (jump) begin
            tc_d = HalfTc;
        end else if (tc_q == LastTc) begin
            tc_d = '0;
        end
    end

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            tc_q <= '0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc_next   = tc_d;
    assign t_pre_mid = (tc_q == HalfTc - 1'b1);
    assign t_mid     = (tc_q == HalfTc);
    assign t_last    = (tc_q == LastTc);

endmodule

// File: rtl/zbus_master.sv
// Z80-side ZX-bus initiator: runs one MREQ/IORQ read or write cycle per command.
// Ports:
//   fclk, zrst_n                    clock / async active-low reset
//   cmd_req/type/addr/wrdata        command in, accepted only when idle
//   cmd_ack                         pulse in the cycle the command is latched
//   rsp_valid/rddata/ioge/tmo       completion pulse and held response fields
//   busy                            a bus cycle is in progress
//   za, zd_out, zd_oe, zd_in        address and data bus
//   zmreq_n, ziorq_n, zrd_n, zwr_n  registered bus strobes
//   zwait_n, ziorqge                wait request (synchronised) and IO claim
module zbus_master
    import zbus_pkg::*;
#(
    parameter int unsigned TDIV     = 4,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        fclk,
    input  logic        zrst_n,
    input  logic        cmd_req,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wrdata,
    output logic        cmd_ack,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rddata,
    output logic        rsp_ioge,
    output logic        rsp_tmo,
    output logic        busy,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        zmreq_n,
    output logic        ziorq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        zwait_n,
    input  logic        ziorqge
);

    localparam int unsigned     CW     = $clog2(TDIV);
    localparam logic [CW-1:0]   HalfTc = CW'(tstate_half(TDIV));

    logic [2:0]    state_q, state_d;
    logic [1:0]    type_q, type_d;
    logic [15:0]   za_q, za_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          go_tw_q, go_tw_d;
    logic [4:0]    wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    cap_data_q, cap_data_d;
    logic          cap_ioge_q, cap_ioge_d;
    logic          mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d;
    logic          rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_ioge_q, rsp_ioge_d, rsp_tmo_q, rsp_tmo_d;
    logic [7:0]    rsp_rddata_q, rsp_rddata_d;
    logic          wait_s1_q, wait_s2_q;

    logic [CW-1:0] tc_next;
    logic          t_pre_mid, t_mid, t_last;
    logic          abort, wait_low, is_io, is_wr;
    logic          lo_half, t1_hi, t2_tw, t3_lo, act;

    zbus_tcnt #(
        .TDIV (TDIV),
        .CW   (CW)
    ) u_tcnt (
        .fclk      (fclk),
        .zrst_n    (zrst_n),
        .clr       (state_q == StIdle),
        .jump      (abort),
        .tc_next   (tc_next),
        .t_pre_mid (t_pre_mid),
        .t_mid     (t_mid),
        .t_last    (t_last)
    );

    assign wait_low = !wait_s2_q;
    assign is_io    = cmd_is_io(type_q);
    assign is_wr    = cmd_is_wr(type_q);

    // Cycle sequencing, wait accounting and response generation.
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        za_d         = za_q;
        wdat_d       = wdat_q;
        go_tw_d      = go_tw_q;
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
        abort        = 1'b0;
        cmd_ack      = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rddata_d = rsp_rddata_q;
        rsp_ioge_d   = rsp_ioge_q;
        rsp_tmo_d    = rsp_tmo_q;
        case (state_q)
            StIdle: begin
                if (cmd_req) begin
                    cmd_ack = 1'b1;
                    state_d = StT1;
                    type_d  = cmd_type;
                    za_d    = cmd_addr;
                    wdat_d  = cmd_wrdata;
                    go_tw_d = 1'b0;
                    wcnt_d  = '0;
                    tmo_d   = 1'b0;
                end
            end
            StT1: begin
                if (t_last) state_d = StT2;
            end
            StT2: begin
                // IO cycles skip the T2 sample: their first TW is unconditional.
                if (t_mid && !is_io) begin
                    go_tw_d = wait_low;
                    if (wait_low && wcnt_q != 5'h1f) wcnt_d = wcnt_q + 5'd1;
                end
                if (t_last) state_d = (is_io || go_tw_d) ? StTw : StT3;
            end
            StTw: begin
                // Too many extra waits: cut this TW at its half point and land on T3 mid.
                if (32'(wcnt_q) > WAIT_MAX && t_pre_mid) begin
                    abort   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = StT3;
                end else begin
                    if (t_mid) begin
                        go_tw_d = wait_low;
                        if (wait_low && wcnt_q != 5'h1f) wcnt_d = wcnt_q + 5'd1;
                    end
                    if (t_last) state_d = go_tw_d ? StTw : StT3;
                end
            end
            StT3: begin
                if (t_last) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_tmo_d   = tmo_q;
                    rsp_ioge_d  = is_io && cap_ioge_q;
                    if (!is_wr) rsp_rddata_d = tmo_q ? 8'hFF : cap_data_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are a function of the next (state, tc) so they come straight from flops.
    always_comb begin
        lo_half    = (tc_next < HalfTc);
        t1_hi      = (state_d == StT1) && !lo_half;
        t2_tw      = (state_d == StT2) || (state_d == StTw);
        t3_lo      = (state_d == StT3) && lo_half;
        act        = is_io ? (t2_tw || t3_lo) : (t1_hi || t2_tw || t3_lo);
        mreq_n_d   = !(act && !is_io);
        iorq_n_d   = !(act && is_io);
        rd_n_d     = !(act && !is_wr);
        wr_n_d     = !(act && is_wr);
        oe_d       = is_wr && (t1_hi || t2_tw || (state_d == StT3));
        // Sample on the last fclk before T3 mid (also covers the timeout jump).
        cap_data_d = cap_data_q;
        cap_ioge_d = cap_ioge_q;
        if (state_d == StT3 && tc_next == HalfTc) begin
            cap_data_d = zd_in;
            cap_ioge_d = ziorqge;
        end
    end

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            state_q      <= StIdle;
            type_q       <= CmdMemRd;
            za_q         <= '0;
            wdat_q       <= '0;
            go_tw_q      <= 1'b0;
            wcnt_q       <= '0;
            tmo_q        <= 1'b0;
            cap_data_q   <= '0;
            cap_ioge_q   <= 1'b0;
            mreq_n_q     <= 1'b1;
            iorq_n_q     <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            oe_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rddata_q <= '0;
            rsp_ioge_q   <= 1'b0;
            rsp_tmo_q    <= 1'b0;
            wait_s1_q    <= 1'b1;
            wait_s2_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            za_q         <= za_d;
            wdat_q       <= wdat_d;
            go_tw_q      <= go_tw_d;
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
            cap_data_q   <= cap_data_d;
            cap_ioge_q   <= cap_ioge_d;
            mreq_n_q     <= mreq_n_d;
            iorq_n_q     <= iorq_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            oe_q         <= oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rddata_q <= rsp_rddata_d;
            rsp_ioge_q   <= rsp_ioge_d;
            rsp_tmo_q    <= rsp_tmo_d;
            wait_s1_q    <= zwait_n;
            wait_s2_q    <= wait_s1_q;
        end
    end

    assign busy       = (state_q != StIdle);
    assign za         = za_q;
    assign zd_out     = wdat_q;
    assign zd_oe      = oe_q;
    assign zmreq_n    = mreq_n_q;
    assign ziorq_n    = iorq_n_q;
    assign zrd_n      = rd_n_q;
    assign zwr_n      = wr_n_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rddata = rsp_rddata_q;
    assign rsp_ioge   = rsp_ioge_q;
    assign rsp_tmo    = rsp_tmo_q;

endmodule
